pwm_capture: RTL
================

# pwm_capture

Measures a PWM waveform with the team's 8-bit, 256-cycle framing and recovers its duty code. It sits on the receive side of a PWM link, in the same clock domain as the sender, and turns the asynchronous `pwm_in` pin back into an 8-bit `pulse_width` with a one-cycle `valid` strobe. Constant-level inputs (codes 0x00 and 0xFF) are detected by timeout. Malformed periods are flagged on `error`.

## Interface
- `SYNC_STAGES`, default 2. Number of synchronizer flops on `pwm_in`; legal range 2..4.
- `TIMEOUT`, default 512. Number of clk cycles without an edge before a constant level is reported; legal range 257..65535.
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `pwm_in` input 1: PWM input, asynchronous to `clk`.
- `pulse_width` output 8: last decoded duty code.
- `valid` output 1: one-cycle strobe when `pulse_width` is updated.
- `error` output 1: one-cycle strobe when a frame is rejected.
- `locked` output 1: high while the last verdict was a valid decode.

## Operation
- **Encoding:**
  - Code N in 1..254 means high for N+1 and low for 255-N of every 256 clk cycles, each period starting with a rising edge.
  - Code 0x00 means constant low. Code 0xFF means constant high.
- **Synchronizer and edge detect:**
  - `pwm_in` passes through `SYNC_STAGES` flops to give `pwm_s`.
  - `pwm_d` is `pwm_s` delayed by one cycle.
  - rise = `pwm_s` & !`pwm_d`; fall = !`pwm_s` & `pwm_d`.
- **Counters:**
  - `high_cnt` and `low_cnt` are 9 bits and saturate at 511.
  - `idle_cnt` is 16 bits. It clears on any rise or fall and otherwise increments.
- **FSM states:** SYNC (reset state), HIGH, LOW.
  - SYNC: wait for a rise, then go to HIGH with `high_cnt`=1.
  - HIGH: increment `high_cnt` each cycle. On fall, go to LOW with `low_cnt`=1.
  - LOW: increment `low_cnt` each cycle. On rise, evaluate the frame, then go to HIGH with `high_cnt`=1.
- **Frame evaluation** (on the rise that exits LOW; sum computed 10 bits wide):
  - If `high_cnt`+`low_cnt` == 256 and `high_cnt` is in 2..255: `pulse_width` ← `high_cnt`-1, `valid` ← 1, `locked` ← 1.
  - Otherwise: `error` ← 1, `locked` ← 0, `pulse_width` holds.
- **Timeout:**
  - Fires when `idle_cnt` == `TIMEOUT`-1 with no edge in the current cycle.
  - `pulse_width` ← `pwm_s` ? 0xFF : 0x00, `valid` ← 1, `locked` ← 1.
  - FSM goes to SYNC and `idle_cnt` ← 0.
  - The report therefore repeats every `TIMEOUT` cycles while the line stays static.
- **Simultaneous events:**
  - An edge in the same cycle as the timeout compare suppresses the timeout, because the edge clears `idle_cnt`.
  - Frame evaluation and timeout can never coincide.
- **Reset:**
  - Asserting `rst_n` low at any time immediately clears every flop: synchronizer, FSM to SYNC, all counters.
  - Outputs reset to `pulse_width`=0x00, `valid`=0, `error`=0, `locked`=0.
  - A partial frame in progress is discarded.

## Timing
- `valid` and `error` are registered, each high for exactly one cycle, and mutually exclusive.
- Latency: let edge k be the first clk edge that samples `pwm_in` high at a period start. `valid` is high during the cycle following edge k+`SYNC_STAGES`.
- `pulse_width` changes only on the edge that raises `valid`, and is stable at all other times.
- **Acquisition:**
  - After reset, or after a timeout, the first rise only aligns the FSM.
  - The first `valid` or `error` comes at the second rise, i.e. one full period later (256 cycles for a legal stream).
- In steady state a legal stream produces exactly one `valid` per 256 cycles.
- Code 0x01 (high 2 cycles) and code 0xFE (low 1 cycle) must decode. The saturating counters must never wrap back into a legal-looking sum.

## Test plan
- **Mid-range code:** continuous code 0x80 stream (high 129, low 127). Required: first `valid` at the second rising edge, `pulse_width`=0x80, then `valid` every 256 cycles, `locked`=1, `error` never asserted.
- **Boundary codes:** stream code 0x01, then switch to 0xFE at a period boundary. Required: `pulse_width`=0x01 then 0xFE, and the first frame of the new code is decoded correctly with no `error`.
- **Static levels:**
  - Hold `pwm_in`=1 from a mid-stream state. Required: after `TIMEOUT`=512 edge-free cycles, `valid` with `pulse_width`=0xFF, repeating every 512 cycles.
  - Hold `pwm_in` low from reset. Required: `valid` with 0x00 after 512 cycles.
- **Bad period:** square wave with period 200 (high 100, low 100) after locking on 0x40. Required: `error` strobe each period, `locked`=0, `pulse_width` stays 0x40, no `valid`.
- **Glitch:** a one-cycle low pulse inside the high phase of a code 0x80 stream. Required: the affected frames yield `error`; decoding recovers to `valid` 0x80 within two periods after the glitch.
- **Reset mid-frame:** assert `rst_n` low halfway through the HIGH phase. Required: outputs are immediately 0x00/0/0/0, and the first `valid` after release comes at the second subsequent rising edge.

Source files
------------

// File: rtl/pwm_capture.sv
// Recovers the 8-bit duty code from a 256-cycle-framed PWM input.
// Static lines (codes 0x00/0xFF) are reported by an edge-free timeout.
module pwm_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [7:0] pulse_width,
    output logic       valid,
    output logic       error,
    output logic       locked
);

    typedef enum logic [1:0] {
        SYNC,
        HIGH,
        LOW
    } state_t;

    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);
    localparam logic [8:0]  CNT_MAX   = '1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_d;
    logic [8:0]             high_cnt;
    logic [8:0]             low_cnt;
    logic [15:0]            idle_cnt;

    logic       pwm_s;
    logic       rise;
    logic       fall;
    logic       timeout_hit;
    logic [9:0] frame_sum;
    logic       frame_ok;
    logic [7:0] decoded;

    always_comb begin
        pwm_s       = sync_q[SYNC_STAGES-1];
        rise        = pwm_s & ~pwm_d;
        fall        = ~pwm_s & pwm_d;
        timeout_hit = (idle_cnt == IDLE_LAST) && !(rise || fall);
        // Counters saturate at 511, so a 10-bit sum can never wrap into 256.
        frame_sum   = {1'b0, high_cnt} + {1'b0, low_cnt};
        frame_ok    = (frame_sum == 10'd256) && (high_cnt >= 9'd2) && (high_cnt <= 9'd255);
        decoded     = 8'(high_cnt - 9'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SYNC;
            sync_q      <= '0;
            pwm_d       <= 1'b0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            idle_cnt    <= '0;
            pulse_width <= '0;
            valid       <= 1'b0;
            error       <= 1'b0;
            locked      <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            pwm_d  <= pwm_s;
            valid  <= 1'b0;
            error  <= 1'b0;

            if (rise || fall || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end

            if (timeout_hit) begin
                state       <= SYNC;
                pulse_width <= pwm_s ? 8'hFF : 8'h00;
                valid       <= 1'b1;
                locked      <= 1'b1;
            end else begin
                case (state)
                    SYNC: begin
                        if (rise) begin
                            state    <= HIGH;
                            high_cnt <= 9'd1;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state   <= LOW;
                            low_cnt <= 9'd1;
                        end else if (high_cnt != CNT_MAX) begin
                            high_cnt <= high_cnt + 9'd1;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            if (frame_ok) begin
                                pulse_width <= decoded;
                                valid       <= 1'b1;
                                locked      <= 1'b1;
                            end else begin
                                error  <= 1'b1;
                                locked <= 1'b0;
                            end
                            state    <= HIGH;
                            high_cnt <= 9'd1;
                        end else if (low_cnt != CNT_MAX) begin
                            low_cnt <= low_cnt + 9'd1;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

endmodule
